// File: rtl/caxi4interconnect_master_addr_router_pkg.sv
// Shared definitions for the master address router: FSM encoding and the
// index of the default-error (DERR) slave.
package caxi4interconnect_master_addr_router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_STALL = 2'd2
    } router_state_t;

    // The DERR slave is always the last slave index.
    function automatic int unsigned derr_slave(input int unsigned num_slaves);
        return num_slaves - 1;
    endfunction

endpackage

// File: rtl/caxi4interconnect_outstanding_counter.sv
// Up/down saturating counter of in-flight transactions. A decrement at zero
// is ignored, an increment at full is blocked unless a decrement frees a slot,
// and a simultaneous increment and decrement leave the count unchanged.
module caxi4interconnect_outstanding_counter #(
    parameter int MAX_COUNT = 8,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 dec,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 full,
    output logic                 empty
);

    logic do_dec;
    logic do_inc;

    assign full  = (count == CNT_WIDTH'(MAX_COUNT));
    assign empty = (count == '0);

    // Qualify the raw requests so the count can never wrap in either direction.
    always_comb begin
        do_dec = dec && !empty;
        do_inc = inc && (!full || do_dec);
    end

    // Count register; both qualified requests together cancel out.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values and simulation matches the synthesized flops.
        if (rst) begin
            count <= '0;
        end else if (do_inc && !do_dec) begin
            count <= count + CNT_WIDTH'(1);
        end else if (do_dec && !do_inc) begin
            count <= count - CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/caxi4interconnect_master_addr_router.sv
// Per-master address router. Picks the target slave from the decoder match
// bits (DERR when nothing matches), holds the request in a one-entry stage
// for the crossbar arbiter, and refuses a request to a different slave while
// earlier transactions are still outstanding so responses return in order.
module caxi4interconnect_master_addr_router
    import caxi4interconnect_master_addr_router_pkg::*;
#(
    parameter int NUM_SLAVES       = 4,
    parameter int NUM_SLAVES_WIDTH = 2,
    parameter int ADDR_WIDTH       = 32,
    parameter int ID_WIDTH         = 4,
    parameter int MAX_OUTSTANDING  = 8,
    parameter int CNT_WIDTH        = 4
) (
    input  logic                        ACLK,
    input  logic                        sysReset,
    input  logic                        MASTER_VALID,
    output logic                        MASTER_READY,
    input  logic [ADDR_WIDTH-1:0]       MASTER_ADDR,
    input  logic [ID_WIDTH-1:0]         MASTER_ID,
    input  logic [NUM_SLAVES-2:0]       match,
    output logic                        REQ_VALID,
    input  logic                        REQ_READY,
    output logic [NUM_SLAVES_WIDTH-1:0] REQ_SLAVE,
    output logic [ADDR_WIDTH-1:0]       REQ_ADDR,
    output logic [ID_WIDTH-1:0]         REQ_ID,
    input  logic                        RESP_DONE,
    output logic [CNT_WIDTH-1:0]        outstanding
);

    router_state_t               state;
    router_state_t               next_state;
    logic [NUM_SLAVES_WIDTH-1:0] sel;
    logic [NUM_SLAVES_WIDTH-1:0] cur_slave;
    logic                        stall;
    logic                        accept;
    logic                        issue;
    logic                        ready_idle;
    logic                        cnt_full;
    logic                        cnt_empty;

    // Lowest-index asserted match bit wins; no match routes to DERR.
    always_comb begin
        sel = NUM_SLAVES_WIDTH'(derr_slave(NUM_SLAVES));
        for (int i = NUM_SLAVES - 2; i >= 0; i--) begin
            if (match[i]) begin
                sel = NUM_SLAVES_WIDTH'(i);
            end
        end
    end

    // A new request must wait if it targets another slave while transactions
    // are in flight, or if the in-flight limit is reached.
    assign stall = (!cnt_empty && (sel != cur_slave)) || cnt_full;

    // State register.
    always_ff @(posedge ACLK) begin
        if (sysReset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        next_state = state;
        ready_idle = 1'b0;
        accept     = 1'b0;
        issue      = 1'b0;
        case (state)
            ST_IDLE: begin
                ready_idle = !stall;
                if (MASTER_VALID) begin
                    if (stall) begin
                        next_state = ST_STALL;
                    end else begin
                        accept     = 1'b1;
                        next_state = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (REQ_READY) begin
                    issue      = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            ST_STALL: begin
                if (!stall) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // The master is never acknowledged while reset is asserted.
    assign MASTER_READY = ready_idle && !sysReset;
    assign REQ_VALID    = (state == ST_HOLD);

    // Holding stage and the slave that owns the in-flight transactions.
    always_ff @(posedge ACLK) begin
        if (sysReset) begin
            REQ_SLAVE <= '0;
            REQ_ADDR  <= '0;
            REQ_ID    <= '0;
            cur_slave <= '0;
        end else begin
            if (accept) begin
                REQ_SLAVE <= sel;
                REQ_ADDR  <= MASTER_ADDR;
                REQ_ID    <= MASTER_ID;
            end
            if (issue) begin
                cur_slave <= REQ_SLAVE;
            end
        end
    end

    caxi4interconnect_outstanding_counter #(
        .MAX_COUNT (MAX_OUTSTANDING),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_outstanding (
        .clk   (ACLK),
        .rst   (sysReset),
        .inc   (issue),
        .dec   (RESP_DONE),
        .count (outstanding),
        .full  (cnt_full),
        .empty (cnt_empty)
    );

endmodule

// File: tb/tb_caxi4interconnect_master_addr_router.sv
// Directed bench for the master address router. A second instance with a
// two-deep outstanding limit shares the inputs to exercise the full condition.
module tb_caxi4interconnect_master_addr_router;

    logic        ACLK = 1'b0;
    logic        sysReset;
    logic        MASTER_VALID;
    logic [31:0] MASTER_ADDR;
    logic [3:0]  MASTER_ID;
    logic [2:0]  match;
    logic        REQ_READY;
    logic        RESP_DONE;

    logic        m_ready,   m_ready2;
    logic        req_valid, req_valid2;
    logic [1:0]  req_slave, req_slave2;
    logic [31:0] req_addr,  req_addr2;
    logic [3:0]  req_id,    req_id2;
    logic [3:0]  outst,     outst2;

    int n_pass  = 0;
    int n_total = 0;

    always #5 ACLK = ~ACLK;

    caxi4interconnect_master_addr_router u_dut (
        .ACLK (ACLK), .sysReset (sysReset),
        .MASTER_VALID (MASTER_VALID), .MASTER_READY (m_ready),
        .MASTER_ADDR (MASTER_ADDR), .MASTER_ID (MASTER_ID), .match (match),
        .REQ_VALID (req_valid), .REQ_READY (REQ_READY), .REQ_SLAVE (req_slave),
        .REQ_ADDR (req_addr), .REQ_ID (req_id),
        .RESP_DONE (RESP_DONE), .outstanding (outst)
    );

    caxi4interconnect_master_addr_router #(.MAX_OUTSTANDING(2)) u_dut2 (
        .ACLK (ACLK), .sysReset (sysReset),
        .MASTER_VALID (MASTER_VALID), .MASTER_READY (m_ready2),
        .MASTER_ADDR (MASTER_ADDR), .MASTER_ID (MASTER_ID), .match (match),
        .REQ_VALID (req_valid2), .REQ_READY (REQ_READY), .REQ_SLAVE (req_slave2),
        .REQ_ADDR (req_addr2), .REQ_ID (req_id2),
        .RESP_DONE (RESP_DONE), .outstanding (outst2)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_total++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic resp_pulse();
        RESP_DONE = 1'b1;
        tick();
        RESP_DONE = 1'b0;
    endtask

    task automatic do_reset();
        sysReset = 1'b1;
        tick();
        tick();
        sysReset = 1'b0;
    endtask

    initial begin
        sysReset     = 1'b1;
        MASTER_VALID = 1'b1;
        MASTER_ADDR  = 32'h0;
        MASTER_ID    = 4'h0;
        match        = 3'b000;
        REQ_READY    = 1'b1;
        RESP_DONE    = 1'b0;

        // Reset state, with VALID held high to show READY stays low.
        tick();
        tick();
        check("rst_master_ready", 32'(m_ready),   32'd0);
        check("rst_req_valid",    32'(req_valid), 32'd0);
        check("rst_req_slave",    32'(req_slave), 32'd0);
        check("rst_req_addr",     req_addr,       32'd0);
        check("rst_req_id",       32'(req_id),    32'd0);
        check("rst_outstanding",  32'(outst),     32'd0);
        MASTER_VALID = 1'b0;
        sysReset     = 1'b0;

        // Test 1: basic request to slave 1, latency 1.
        MASTER_VALID = 1'b1; match = 3'b010; MASTER_ADDR = 32'h1000; MASTER_ID = 4'd5;
        #1;
        check("t1_ready_idle", 32'(m_ready), 32'd1);
        tick();
        MASTER_VALID = 1'b0;
        check("t1_req_valid", 32'(req_valid), 32'd1);
        check("t1_req_slave", 32'(req_slave), 32'd1);
        check("t1_req_id",    32'(req_id),    32'd5);
        check("t1_req_addr",  req_addr,       32'h1000);
        check("t1_ready_hold", 32'(m_ready),  32'd0);
        tick();
        check("t1_req_valid_drop", 32'(req_valid), 32'd0);
        check("t1_outstanding",    32'(outst),     32'd1);

        // Test 2: no match goes to DERR, multiple matches pick lowest index.
        resp_pulse();
        check("t2_drain0", 32'(outst), 32'd0);
        MASTER_VALID = 1'b1; match = 3'b000; MASTER_ADDR = 32'hF000_0000; MASTER_ID = 4'd1;
        #1;
        check("t2_ready_derr", 32'(m_ready), 32'd1);
        tick();
        MASTER_VALID = 1'b0;
        check("t2_slave_derr", 32'(req_slave), 32'd3);
        tick();
        check("t2_out_derr", 32'(outst), 32'd1);
        resp_pulse();
        check("t2_drain1", 32'(outst), 32'd0);
        MASTER_VALID = 1'b1; match = 3'b110; MASTER_ADDR = 32'h1004; MASTER_ID = 4'd2;
        tick();
        MASTER_VALID = 1'b0;
        check("t2_slave_lowest", 32'(req_slave), 32'd1);
        tick();
        check("t2_out_lowest", 32'(outst), 32'd1);

        // Test 3: count=1 on slave 1, request to slave 2 stalls until drained.
        MASTER_VALID = 1'b1; match = 3'b100; MASTER_ADDR = 32'h2000; MASTER_ID = 4'd7;
        #1;
        check("t3_ready_stall_idle", 32'(m_ready), 32'd0);
        tick();
        check("t3_ready_stall", 32'(m_ready),   32'd0);
        check("t3_no_req",      32'(req_valid), 32'd0);
        resp_pulse();
        check("t3_out_drained",  32'(outst),   32'd0);
        check("t3_ready_in_stall", 32'(m_ready), 32'd0);
        tick();
        check("t3_ready_back", 32'(m_ready), 32'd1);
        tick();
        MASTER_VALID = 1'b0;
        check("t3_req_slave", 32'(req_slave), 32'd2);
        check("t3_req_addr",  req_addr,       32'h2000);
        tick();
        check("t3_out_issue", 32'(outst), 32'd1);

        // Test 5: issue and response in the same cycle, then response at zero.
        MASTER_VALID = 1'b1; match = 3'b100; MASTER_ADDR = 32'h2010; MASTER_ID = 4'd3;
        tick();
        MASTER_VALID = 1'b0;
        check("t5_hold", 32'(req_valid), 32'd1);
        RESP_DONE = 1'b1;
        tick();
        RESP_DONE = 1'b0;
        check("t5_out_same_cycle", 32'(outst), 32'd1);
        RESP_DONE = 1'b1;
        tick();
        check("t5_out_to_zero", 32'(outst), 32'd0);
        tick();
        RESP_DONE = 1'b0;
        check("t5_out_floor", 32'(outst), 32'd0);

        // Test 6: backpressure in HOLD, then reset drops the request.
        MASTER_VALID = 1'b1; match = 3'b001; MASTER_ADDR = 32'h0000_0040; MASTER_ID = 4'd4;
        tick();
        MASTER_VALID = 1'b0;
        tick();
        check("t6_pre_out", 32'(outst), 32'd1);
        REQ_READY = 1'b0;
        MASTER_VALID = 1'b1; match = 3'b001; MASTER_ADDR = 32'hABCD_0004; MASTER_ID = 4'd9;
        tick();
        MASTER_ADDR = 32'h5555_5550; MASTER_ID = 4'd6; match = 3'b100;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t6_hold_valid", 32'(req_valid), 32'd1);
            check("t6_hold_addr",  req_addr,       32'hABCD_0004);
            check("t6_hold_id",    32'(req_id),    32'd9);
            check("t6_hold_slave", 32'(req_slave), 32'd0);
            check("t6_hold_ready", 32'(m_ready),   32'd0);
        end
        MASTER_VALID = 1'b0;
        check("t6_out_held", 32'(outst), 32'd1);
        sysReset = 1'b1;
        tick();
        check("t6_rst_req_valid", 32'(req_valid), 32'd0);
        check("t6_rst_out",       32'(outst),     32'd0);
        sysReset  = 1'b0;
        REQ_READY = 1'b1;
        do_reset();

        // Test 4: limit of two on the second instance.
        for (int k = 0; k < 2; k++) begin
            MASTER_VALID = 1'b1; match = 3'b001; MASTER_ADDR = 32'h100 + 32'(k); MASTER_ID = 4'(k);
            tick();
            MASTER_VALID = 1'b0;
            tick();
        end
        check("t4_out_full", 32'(outst2), 32'd2);
        MASTER_VALID = 1'b1; match = 3'b001; MASTER_ADDR = 32'h0000_0300; MASTER_ID = 4'd12;
        #1;
        check("t4_ready_full", 32'(m_ready2), 32'd0);
        tick();
        check("t4_ready_stall",  32'(m_ready2),   32'd0);
        check("t4_no_req",       32'(req_valid2), 32'd0);
        resp_pulse();
        check("t4_out_after_resp", 32'(outst2), 32'd1);
        tick();
        check("t4_ready_back", 32'(m_ready2), 32'd1);
        tick();
        MASTER_VALID = 1'b0;
        check("t4_req_valid", 32'(req_valid2), 32'd1);
        check("t4_req_slave", 32'(req_slave2), 32'd0);
        check("t4_req_addr",  req_addr2,       32'h0000_0300);
        check("t4_req_id",    32'(req_id2),    32'd12);
        tick();
        check("t4_out_refull", 32'(outst2), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
